// File: rtl/eff_ctrl.sv
// Effect-selection controller: debounces three footswitches and sequences en/sel changes.
// Define EFF_CTRL_MUTE_EN to wrap each change in a sample-counted mute/settle window.
module eff_ctrl #(
    parameter int NUM_EFF      = 4,
    parameter int DEB_CYCLES   = 1_000_000,
    parameter int MUTE_SAMPLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next_i,
    input  logic        btn_prev_i,
    input  logic        btn_byp_i,
    input  logic        vld_i,
    output logic        en_o,
    output logic [15:0] sel_o,
    output logic [3:0]  idx_o,
    output logic        mute_o,
    output logic        busy_o
);
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd2;
`ifdef EFF_CTRL_MUTE_EN
    localparam logic [1:0] S_MUTE   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd3;
    localparam logic [1:0] S_ENTRY  = S_MUTE;
    localparam logic [1:0] S_AFTER  = S_SETTLE;
`else
    localparam logic [1:0] S_ENTRY  = S_APPLY;
    localparam logic [1:0] S_AFTER  = S_IDLE;
`endif

    // Button vectors are ordered {byp, next, prev}, highest priority first.
    logic [2:0] raw, sync1, sync2, stable, stable_q, press;
    assign raw = {btn_byp_i, btn_next_i, btn_prev_i};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable_q <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_deb
        logic          st;
        logic [DW-1:0] cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                st  <= 1'b0;
                cnt <= '0;
            end else if (sync2[g] == st) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                st  <= sync2[g];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign stable[g] = st;
    end

    // Only the rising edge of the debounced level counts as a press.
    assign press = stable & ~stable_q;

    logic [3:0] idx_inc, idx_dec;
    assign idx_inc = (idx_o == 4'(NUM_EFF - 1)) ? 4'd0 : idx_o + 4'd1;
    assign idx_dec = (idx_o == 4'd0) ? 4'(NUM_EFF - 1) : idx_o - 4'd1;

    logic [1:0] state, state_d;
    logic       pend_en;
    logic [3:0] pend_idx;

`ifdef EFF_CTRL_MUTE_EN
    localparam int CW = $clog2(MUTE_SAMPLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUTE_SAMPLES - 1);
    logic [CW-1:0] smp_cnt;
    logic          last_smp;
    assign last_smp = vld_i && (smp_cnt == CNT_LAST);
`else
    logic unused_vld;
    assign unused_vld = vld_i;
`endif

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (|press) state_d = S_ENTRY;
            S_APPLY:  state_d = S_AFTER;
`ifdef EFF_CTRL_MUTE_EN
            S_MUTE:   if (last_smp) state_d = S_APPLY;
            S_SETTLE: if (last_smp) state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            busy_o   <= 1'b0;
            en_o     <= 1'b0;
            idx_o    <= 4'd0;
            sel_o    <= 16'h0001;
            pend_en  <= 1'b0;
            pend_idx <= 4'd0;
        end else begin
            state  <= state_d;
            busy_o <= (state_d != S_IDLE);
            if (state == S_IDLE && |press) begin
                if (press[2]) begin
                    pend_en  <= ~en_o;
                    pend_idx <= idx_o;
                end else if (press[1]) begin
                    pend_en  <= en_o;
                    pend_idx <= idx_inc;
                end else begin
                    pend_en  <= en_o;
                    pend_idx <= idx_dec;
                end
            end
            if (state == S_APPLY) begin
                en_o  <= pend_en;
                idx_o <= pend_idx;
                sel_o <= 16'(1) << pend_idx;
            end
        end
    end

`ifdef EFF_CTRL_MUTE_EN
    // Mute covers MUTE, APPLY and SETTLE; vld_i arriving during APPLY is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mute_o  <= 1'b0;
            smp_cnt <= '0;
        end else begin
            mute_o <= (state_d != S_IDLE);
            if (state == S_MUTE || state == S_SETTLE) begin
                if (vld_i) smp_cnt <= smp_cnt + 1'b1;
            end else begin
                smp_cnt <= '0;
            end
        end
    end
`else
    assign mute_o = 1'b0;
`endif

endmodule

// File: tb/tb_eff_ctrl.sv
// Bench for eff_ctrl: directed timing checks plus randomized presses scored against a queue.
// Follows the RTL build: EFF_CTRL_MUTE_EN selects which timing is expected.
module tb_eff_ctrl;
    localparam int NUM_EFF = 4;
    localparam int DEB     = 4;
    localparam int MS      = 3;
    localparam int W       = 5;

    logic        clk, rst;
    logic        btn_next_i, btn_prev_i, btn_byp_i, vld_i;
    logic        en_o, mute_o, busy_o;
    logic [15:0] sel_o;
    logic [3:0]  idx_o;

    eff_ctrl #(.NUM_EFF(NUM_EFF), .DEB_CYCLES(DEB), .MUTE_SAMPLES(MS)) dut (
        .clk(clk), .rst(rst),
        .btn_next_i(btn_next_i), .btn_prev_i(btn_prev_i), .btn_byp_i(btn_byp_i),
        .vld_i(vld_i),
        .en_o(en_o), .sel_o(sel_o), .idx_o(idx_o), .mute_o(mute_o), .busy_o(busy_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic         m_en  = 1'b0;
    int           m_idx = 0;

    logic rand_vld = 1'b0;
    logic vld_dir  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted press resolves by priority byp > next > prev.
    function automatic void model_press(input logic [2:0] m);
        if (m[2])      m_en  = ~m_en;
        else if (m[1]) m_idx = (m_idx == NUM_EFF - 1) ? 0 : m_idx + 1;
        else if (m[0]) m_idx = (m_idx == 0) ? NUM_EFF - 1 : m_idx - 1;
        exp_q.push_back({m_en, 4'(m_idx)});
    endfunction

    // Sample strobe driver: random when rand_vld, otherwise follows vld_dir.
    initial begin
        vld_i = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            vld_i = rand_vld ? ($urandom_range(0, 3) == 0) : vld_dir;
        end
    end

    // Monitor: every change of en/idx must match the oldest pending expectation.
    initial begin : monitor
        logic         prev_en;
        logic [3:0]   prev_idx;
        logic [W-1:0] e;
        prev_en  = 1'b0;
        prev_idx = 4'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en  = 1'b0;
                prev_idx = 4'd0;
            end else if (en_o !== prev_en || idx_o !== prev_idx) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_change", 32'({en_o, idx_o}), 32'({prev_en, prev_idx}));
                end else begin
                    e = exp_q.pop_front();
                    check("sb_en", 32'(en_o), 32'(e[4]));
                    check("sb_idx", 32'(idx_o), 32'(e[3:0]));
                    check("sb_sel", 32'(sel_o), 32'(16'(1) << e[3:0]));
`ifdef EFF_CTRL_MUTE_EN
                    check("sb_mute_during_change", 32'(mute_o), 32'(1));
`endif
                end
                prev_en  = en_o;
                prev_idx = idx_o;
            end
        end
    end

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btns(input logic [2:0] m);
        {btn_byp_i, btn_next_i, btn_prev_i} = m;
    endtask

    task automatic send_strobe(input int gap);
        cycles(gap - 1);
        vld_dir = 1'b1;
        @(negedge clk);
        vld_dir = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy_o === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'(busy_o), 32'(0));
    endtask

    task automatic press(input logic [2:0] m, input int hold);
        @(negedge clk);
        set_btns(m);
        model_press(m);
        cycles(hold);
        set_btns(3'b000);
        cycles(DEB + 4);
        wait_idle(2000);
    endtask

    task automatic bounce(input logic [2:0] m);
        repeat ($urandom_range(2, 5)) begin
            @(negedge clk);
            set_btns(m);
            cycles($urandom_range(1, DEB - 1) - 1);
            @(negedge clk);
            set_btns(3'b000);
            cycles($urandom_range(1, 2) - 1);
        end
        cycles(DEB + 4);
    endtask

    initial begin : watchdog
        #400_000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int busy_seen;
        rst = 1'b1;
        set_btns(3'b000);
        cycles(3);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        check("rst_en", 32'(en_o), 32'(0));
        check("rst_sel", 32'(sel_o), 32'h0001);
        check("rst_idx", 32'(idx_o), 32'(0));
        check("rst_mute", 32'(mute_o), 32'(0));
        check("rst_busy", 32'(busy_o), 32'(0));

        // first press: edge-exact timing of mute/busy and the update
        rand_vld = 1'b0;
        @(negedge clk);
        btn_next_i = 1'b1;
        model_press(3'b010);
        cycles(DEB + 2);
        check("t2_busy_pre", 32'(busy_o), 32'(0));
        check("t2_mute_pre", 32'(mute_o), 32'(0));
        @(negedge clk);
        check("t2_busy_rise", 32'(busy_o), 32'(1));
        check("t2_idx_hold", 32'(idx_o), 32'(0));
`ifdef EFF_CTRL_MUTE_EN
        check("t2_mute_rise", 32'(mute_o), 32'(1));
        cycles(10 - (DEB + 3));
        btn_next_i = 1'b0;
        send_strobe(8);
        send_strobe(8);
        send_strobe(8);
        check("t2_idx_apply_cycle", 32'(idx_o), 32'(0));
        @(negedge clk);
        check("t2_idx_new", 32'(idx_o), 32'(1));
        check("t2_sel_new", 32'(sel_o), 32'h0002);
        check("t2_mute_settle", 32'(mute_o), 32'(1));
        send_strobe(8);
        send_strobe(8);
        check("t2_mute_before_last", 32'(mute_o), 32'(1));
        send_strobe(8);
        check("t2_mute_fall", 32'(mute_o), 32'(0));
        check("t2_busy_fall", 32'(busy_o), 32'(0));
`else
        check("t2_mute_tied", 32'(mute_o), 32'(0));
        @(negedge clk);
        check("t2_busy_one_cycle", 32'(busy_o), 32'(0));
        check("t2_idx_new", 32'(idx_o), 32'(1));
        check("t2_sel_new", 32'(sel_o), 32'h0002);
        cycles(10 - (DEB + 4));
        btn_next_i = 1'b0;
`endif
        cycles(DEB + 4);

        // wrap-around in both directions
        rand_vld = 1'b1;
        press(3'b001, 10);
        press(3'b001, 10);
        check("t3_idx_wrap_prev", 32'(idx_o), 32'(3));
        check("t3_sel_wrap_prev", 32'(sel_o), 32'h0008);
        press(3'b010, 10);
        check("t3_idx_wrap_next", 32'(idx_o), 32'(0));

        // short bounces must never produce a press
        busy_seen = 0;
        repeat (5) begin
            @(negedge clk);
            btn_next_i = 1'b1;
            repeat (3) begin
                @(negedge clk);
                if (busy_o) busy_seen++;
            end
            btn_next_i = 1'b0;
            if (busy_o) busy_seen++;
        end
        check("t4_bounce_no_busy", 32'(busy_seen), 32'(0));
        press(3'b010, 6);
        check("t4_idx_after_hold", 32'(idx_o), 32'(m_idx));

        // coincident byp+next: byp wins; a press while busy is dropped
        rand_vld = 1'b0;
        @(negedge clk);
        set_btns(3'b110);
        model_press(3'b110);
        cycles(10);
        set_btns(3'b000);
        cycles(DEB + 4);
`ifdef EFF_CTRL_MUTE_EN
        check("t5_busy_in_mute", 32'(busy_o), 32'(1));
        @(negedge clk);
        btn_next_i = 1'b1;
        cycles(10);
        btn_next_i = 1'b0;
        cycles(DEB + 4);
`endif
        rand_vld = 1'b1;
        wait_idle(2000);
        check("t5_en_toggled", 32'(en_o), 32'(1));
        check("t5_idx_kept", 32'(idx_o), 32'(m_idx));

        // reset in the middle of a sequence discards the pending change
        rand_vld = 1'b0;
        @(negedge clk);
        btn_next_i = 1'b1;
        model_press(3'b010);
        cycles(DEB + 2);
        btn_next_i = 1'b0;
        @(negedge clk);
        check("t6_busy_before_rst", 32'(busy_o), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        m_en  = 1'b0;
        m_idx = 0;
        check("t6_rst_mute", 32'(mute_o), 32'(0));
        check("t6_rst_busy", 32'(busy_o), 32'(0));
        check("t6_rst_idx", 32'(idx_o), 32'(0));
        check("t6_rst_en", 32'(en_o), 32'(0));
        check("t6_rst_sel", 32'(sel_o), 32'h0001);
        @(negedge clk);
        rst = 1'b0;
        cycles(DEB + 4);
        check("t6_no_replay", 32'(busy_o), 32'(0));

        // randomized presses and bounces
        rand_vld = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 4) == 0)
                bounce(3'($urandom_range(1, 7)));
            else
                press(3'($urandom_range(1, 7)), $urandom_range(DEB + 2, DEB + 8));
        end

        rand_vld = 1'b0;
        cycles(20);
        check("exp_q_drained", 32'(exp_q.size()), 32'(0));
        check("final_en", 32'(en_o), 32'(m_en));
        check("final_idx", 32'(idx_o), 32'(m_idx));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/eff_ctrl.md
# eff_ctrl

Effect-selection controller for the effect pipeline. It debounces three raw footswitch inputs (next effect, previous effect, bypass toggle) and owns the `en` / one-hot `sel` configuration that drives the effect pipe. It sequences every configuration change around a sample-counted output mute so that a switch never produces a click. It sits between the board button I/O and the effect pipe, in the audio clock domain.

## Interface

**Parameters**
- `NUM_EFF`, default 4: number of selectable effects, legal range 1..16.
- `DEB_CYCLES`, default 1_000_000: debounce stability window in clk cycles, ≥1.
- `MUTE_SAMPLES`, default 64: `vld_i` strobes counted in each of the MUTE and SETTLE phases, ≥1.

**Ports** (one clock; reset is synchronous and active-high)
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `btn_next_i` in 1: raw, asynchronous next-effect footswitch, active-high.
- `btn_prev_i` in 1: raw, asynchronous previous-effect footswitch.
- `btn_byp_i` in 1: raw, asynchronous bypass-toggle footswitch.
- `vld_i` in 1: sample strobe, the same as the pipe's input valid.
- `en_o` out 1: effect enable (1 = effect active, 0 = bypass).
- `sel_o` out 16: one-hot effect select, equal to `1 << idx_o`.
- `idx_o` out 4: current effect index.
- `mute_o` out 1: request to downstream to force output samples to zero.
- `busy_o` out 1: high when the FSM is not in IDLE.

## Operation

**Input conditioning**
- Each button passes through a 2-flop synchronizer, then a debouncer with a stable state and a counter.
- The counter increments while the synchronized level differs from the stable state, and clears when they match.
- When the counter equals `DEB_CYCLES-1` and the levels still differ, the stable state takes the new level and the counter clears.
- A press is a one-cycle pulse, `stable & ~stable_q`, generated on the rising edge of the stable state only.

**Event arbitration (IDLE only)**
- Priority when pulses coincide: byp > next > prev. Lower-priority pulses in the same cycle are dropped.
- Pulses arriving while `busy_o` = 1 are dropped. There is no queue.
- Target computation:
  - next: `idx` = `idx==NUM_EFF-1 ? 0 : idx+1`.
  - prev: `idx` = `idx==0 ? NUM_EFF-1 : idx-1`.
  - byp: `en` = ~`en`.
- Targets are captured into pending registers on the IDLE exit edge.

**FSM** (with `EFF_CTRL_MUTE_EN` defined)
- IDLE → MUTE on an accepted press. The sample counter clears and `mute_o` goes to 1.
- MUTE: count `vld_i` strobes. On the strobe that makes the count equal `MUTE_SAMPLES`, go to APPLY.
- APPLY, one cycle:
  - Load `idx_o`, `sel_o` and `en_o` from the pending registers.
  - Clear the counter and go to SETTLE.
  - `vld_i` is ignored in this cycle.
- SETTLE: `mute_o` stays 1. Count `MUTE_SAMPLES` strobes, then go to IDLE with `mute_o` = 0 on that same edge.
- Counter width is `$clog2(MUTE_SAMPLES+1)`. It never wraps.

**Outputs and reset**
- `sel_o` bits at index ≥ `NUM_EFF` are always 0.
- `busy_o` = (state != IDLE), registered.
- Reset values:
  - `en_o` = 0, `idx_o` = 0, `sel_o` = 16'h0001, `mute_o` = 0, `busy_o` = 0.
  - State = IDLE, counters = 0, debounce stable states = 0.
- Reset asserted mid-sequence aborts it. The pending change is discarded and the outputs above are restored on the next edge.

## Timing

- Raw level sampled at edge E0 and held → stable state updates at E0+`DEB_CYCLES`+1. The press pulse is high in the following cycle.
- Bounce shorter than `DEB_CYCLES` consecutive cycles produces no pulse.
- Release (falling stable edge) produces no pulse.
- Macro defined:
  - `mute_o`/`busy_o` rise at E0+`DEB_CYCLES`+2.
  - Outputs change one cycle after the `MUTE_SAMPLES`-th strobe.
  - `mute_o` falls on the edge sampling the `MUTE_SAMPLES`-th SETTLE strobe.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration

`EFF_CTRL_MUTE_EN`
- Defined: full IDLE→MUTE→APPLY→SETTLE→IDLE sequence as above.
- Undefined:
  - MUTE and SETTLE are not built. `mute_o` is tied to 0.
  - The FSM runs IDLE→APPLY→IDLE.
  - `en_o`/`sel_o`/`idx_o` update at E0+`DEB_CYCLES`+3.
  - `busy_o` is high for exactly one cycle.
  - `vld_i` is unused.

## Test plan

1. Reset with all buttons low → `en_o`=0, `sel_o`=16'h0001, `idx_o`=0, `mute_o`=0, `busy_o`=0.
2. `DEB_CYCLES`=4, `NUM_EFF`=4, macro on, `MUTE_SAMPLES`=3, `vld_i` every 8 cycles. Hold next high for 10 cycles:
   - `mute_o` rises at E0+6.
   - `idx_o`=1 and `sel_o`=16'h0002 one cycle after the 3rd strobe.
   - `mute_o` falls at the 6th strobe.
3. Prev pressed from `idx_o`=0 → `idx_o`=3, `sel_o`=16'h0008. Then next from 3 → `idx_o`=0.
4. Bounce: next toggles high for 3 cycles, low for 1, repeated ×5 → no pulse and `busy_o` stays 0. Then held for 6 cycles → exactly one change.
5. byp and next pulse in the same cycle → only `en_o` toggles 0→1 and `idx_o` is unchanged. A next press during MUTE is dropped.
6. `rst` asserted mid-MUTE → next edge gives `mute_o`=0, `busy_o`=0, `idx_o`=0, `en_o`=0. Macro off: a press updates `sel_o` at E0+7 and `busy_o` is high for one cycle.
